uart_rx_memctrl: RTL

//  Receive side of the serial link driven by the uart transmitter toward the memory controller.

---
 rtl/uart_rx_memctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_memctrl.sv
// Serial receiver feeding the memory controller: deserialises parity-protected frames
// and issues one memory write per good word across a burst of word_number words.
module uart_rx_memctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int WORDNUM_WIDTH = 8,
  parameter int CLKS_PER_BIT  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  input  logic                     uart_memctrl_read_ready,
  input  logic [ADDR_WIDTH-1:0]    uart_mem_addr,
  input  logic [WORDNUM_WIDTH-1:0] word_number,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic [ADDR_WIDTH-1:0]    mem_write_addr,
  output logic                     mem_write_valid,
  output logic                     bus_error,
  output logic                     rx_busy,
  output logic                     burst_done
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [TMR_W-1:0] HALF_M1  = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_M1  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    START,
    DATA,
    PARITY,
    STOP,
    WRITE
  } state_t;

  state_t                   state, state_nxt;
  logic                     rx_p0, rx_p1;
  logic [TMR_W-1:0]         timer;
  logic [BIT_W-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0]    shift_reg;
  logic                     par_bit;
  logic [ADDR_WIDTH-1:0]    cur_addr;
  logic [WORDNUM_WIDTH-1:0] word_cnt;
  logic [WORDNUM_WIDTH-1:0] word_idx;
  logic                     zero_pend;

  logic accept, half_tick, full_tick, stop_tick, frame_ok, last_word;

  // Even parity over payload plus parity bit, and a high stop bit.
  function automatic logic frame_good(input logic [DATA_WIDTH-1:0] d,
                                      input logic p, input logic stop);
    return ~(^d ^ p) & stop;
  endfunction

  assign accept    = (state == IDLE) && uart_memctrl_read_ready && !rx_busy;
  assign half_tick = (state == START) && (timer == HALF_M1);
  assign full_tick = (timer == FULL_M1);
  assign stop_tick = (state == STOP) && full_tick;
  assign frame_ok  = frame_good(shift_reg, par_bit, rx_p1);
  assign last_word = (word_idx == word_cnt - 1'b1);

  // Stage p0/p1: rx synchroniser, preset to line-idle level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept && (word_number != '0)) state_nxt = WAIT_START;
      WAIT_START: if (!rx_p1) state_nxt = START;
      START:      if (half_tick) state_nxt = rx_p1 ? WAIT_START : DATA;
      DATA:       if (full_tick && (bit_cnt == LAST_BIT)) state_nxt = PARITY;
      PARITY:     if (full_tick) state_nxt = STOP;
      STOP:       if (full_tick) state_nxt = WRITE;
      WRITE:      state_nxt = rx_busy ? WAIT_START : IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Bit timing: mid-bit sample in START, then one sample every CLKS_PER_BIT cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        START: begin
          timer   <= half_tick ? '0 : timer + 1'b1;
          bit_cnt <= '0;
        end
        DATA: begin
          timer <= full_tick ? '0 : timer + 1'b1;
          if (full_tick) bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY, STOP: timer <= full_tick ? '0 : timer + 1'b1;
        default:      timer <= '0;
      endcase
    end
  end

  // Payload shift register and parity capture carry no reset; they are rebuilt every frame.
  always_ff @(posedge clk) begin
    if ((state == DATA) && full_tick) shift_reg <= {rx_p1, shift_reg[DATA_WIDTH-1:1]};
    if ((state == PARITY) && full_tick) par_bit <= rx_p1;
  end

  // Burst bookkeeping and registered write/handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr        <= '0;
      word_cnt        <= '0;
      word_idx        <= '0;
      zero_pend       <= 1'b0;
      mem_write_data  <= '0;
      mem_write_addr  <= '0;
      mem_write_valid <= 1'b0;
      bus_error       <= 1'b0;
      rx_busy         <= 1'b0;
      burst_done      <= 1'b0;
    end else begin
      mem_write_valid <= 1'b0;
      burst_done      <= 1'b0;
      if (accept) begin
        cur_addr  <= uart_mem_addr;
        word_cnt  <= word_number;
        word_idx  <= '0;
        bus_error <= 1'b0;
        rx_busy   <= 1'b1;
        zero_pend <= (word_number == '0);
      end
      if (zero_pend) begin
        zero_pend  <= 1'b0;
        burst_done <= 1'b1;
        rx_busy    <= 1'b0;
      end
      if (stop_tick) begin
        if (frame_ok) begin
          mem_write_valid <= 1'b1;
          mem_write_data  <= shift_reg;
          mem_write_addr  <= cur_addr;
        end else begin
          bus_error <= 1'b1;
        end
        // Bad words still consume their address slot.
        cur_addr <= cur_addr + 1'b1;
        word_idx <= word_idx + 1'b1;
        if (last_word) begin
          burst_done <= 1'b1;
          rx_busy    <= 1'b0;
        end
      end
    end
  end

endmodule
